gesture_cmd_arbiter: RTL and testbench

- Shares one 2-bit gesture input of the downstream set/clear/toggle Moore detector between two requesters.
- Each requester submits a command opcode over a req/ack handshake.
- The block grants requesters round-robin and serialises each command into the code-then-idle gesture the detector recognises.
- It also keeps a shadow copy of the detector's expected output for checking.

---
 rtl/gesture_cmd_arbiter_pkg.sv | 28 ++
 rtl/gesture_cmd_arbiter_rr_arb2.sv | 35 +++
 rtl/gesture_cmd_arbiter.sv | 142 ++++++++++++++
 tb/tb_gesture_cmd_arbiter.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/gesture_cmd_arbiter_pkg.sv
// Shared opcode and state definitions for the gesture command arbiter and its detector bench.
// Also provides the detector output prediction used for the shadow copy.
package gesture_cmd_arbiter_pkg;

  localparam logic [1:0] OP_SET = 2'b11;
  localparam logic [1:0] OP_CLR = 2'b01;
  localparam logic [1:0] OP_TGL = 2'b10;
  localparam logic [1:0] OP_NOP = 2'b00;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_GAP   = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  function automatic logic next_shadow(input logic [1:0] op, input logic cur);
    logic nxt;
    case (op)
      OP_SET:  nxt = 1'b1;
      OP_CLR:  nxt = 1'b0;
      OP_TGL:  nxt = ~cur;
      default: nxt = cur;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/gesture_cmd_arbiter_rr_arb2.sv
// Two-way round-robin arbiter: on a tie the requester that was not served last wins.
module rr_arb2
  import gesture_cmd_arbiter_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic       last_grant_i,
  output logic       grant_valid_o,
  output logic       grant_id_o
);

  // Pick a winner among the active requests.
  always_comb begin
    grant_valid_o = 1'b0;
    grant_id_o    = 1'b0;
    case (req_i)
      2'b01: begin
        grant_valid_o = 1'b1;
        grant_id_o    = 1'b0;
      end
      2'b10: begin
        grant_valid_o = 1'b1;
        grant_id_o    = 1'b1;
      end
      2'b11: begin
        grant_valid_o = 1'b1;
        grant_id_o    = ~last_grant_i;
      end
      default: begin
        grant_valid_o = 1'b0;
        grant_id_o    = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/gesture_cmd_arbiter.sv
// Arbitrates two command requesters onto one 2-bit gesture line, serialising each opcode
// as code-then-idle and tracking the detector's expected output in shadow_y.
module gesture_cmd_arbiter
  import gesture_cmd_arbiter_pkg::*;
#(
  parameter int unsigned CODE_CYCLES = 1,
  parameter int unsigned GAP_CYCLES  = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req0,
  input  logic [1:0] op0,
  input  logic       req1,
  input  logic [1:0] op1,
  output logic       ack0,
  output logic       ack1,
  output logic       err,
  output logic       busy,
  output logic       grant_id,
  output logic [1:0] ain_out,
  output logic       shadow_y
);

  localparam logic [3:0] CODE_LOAD = 4'(CODE_CYCLES - 1);
  localparam logic [3:0] GAP_LOAD  = 4'(GAP_CYCLES - 1);

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [1:0] op_q, op_d;
  logic       gid_q, gid_d;
  logic       last_q, last_d;
  logic [1:0] ain_q, ain_d;
  logic       ack0_q, ack0_d;
  logic       ack1_q, ack1_d;
  logic       err_q, err_d;
  logic       busy_q, busy_d;
  logic       shadow_q, shadow_d;

  logic       arb_valid;
  logic       arb_id;
  logic [1:0] sel_op;

  rr_arb2 u_arb (
    .req_i         ({req1, req0}),
    .last_grant_i  (last_q),
    .grant_valid_o (arb_valid),
    .grant_id_o    (arb_id)
  );

  assign sel_op = arb_id ? op1 : op0;

  // Next-state logic; outputs are derived from the next state so they are all registered.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    gid_d    = gid_q;
    last_d   = last_q;
    shadow_d = shadow_q;
    case (state_q)
      ST_IDLE: begin
        if (arb_valid) begin
          gid_d  = arb_id;
          last_d = arb_id;
          op_d   = sel_op;
          if (sel_op == OP_NOP) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_DRIVE;
            cnt_d   = CODE_LOAD;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_DRIVE: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_GAP;
          cnt_d   = GAP_LOAD;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_GAP: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_DONE: begin
        shadow_d = next_shadow(op_q, shadow_q);
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    ain_d  = (state_d == ST_DRIVE) ? op_d : OP_NOP;
    ack0_d = (state_d == ST_DONE) && (gid_d == 1'b0);
    ack1_d = (state_d == ST_DONE) && (gid_d == 1'b1);
    err_d  = (state_d == ST_DONE) && (op_d == OP_NOP);
    busy_d = (state_d != ST_IDLE);
  end

  // State, counter, latched command and registered outputs; reset aborts any command.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= 4'd0;
      op_q     <= OP_NOP;
      gid_q    <= 1'b0;
      last_q   <= 1'b1;
      ain_q    <= OP_NOP;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
      shadow_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      gid_q    <= gid_d;
      last_q   <= last_d;
      ain_q    <= ain_d;
      ack0_q   <= ack0_d;
      ack1_q   <= ack1_d;
      err_q    <= err_d;
      busy_q   <= busy_d;
      shadow_q <= shadow_d;
    end
  end

  assign ack0     = ack0_q;
  assign ack1     = ack1_q;
  assign err      = err_q;
  assign busy     = busy_q;
  assign grant_id = gid_q;
  assign ain_out  = ain_q;
  assign shadow_y = shadow_q;

endmodule

// File: tb/tb_gesture_cmd_arbiter.sv
// Directed bench for gesture_cmd_arbiter: default instance plus a CODE=3/GAP=4 instance,
// each watched by a small code-then-idle detector model.
module tb_gesture_cmd_arbiter;
  import gesture_cmd_arbiter_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic       req0, req1, ack0, ack1, err, busy, grant_id, shadow_y;
  logic [1:0] op0, op1, ain_out;
  logic       s_req0, s_req1, s_ack0, s_ack1, s_err, s_busy, s_grant_id, s_shadow_y;
  logic [1:0] s_op0, s_op1, s_ain_out;

  gesture_cmd_arbiter dut (
    .clk(clk), .reset(reset), .req0(req0), .op0(op0), .req1(req1), .op1(op1),
    .ack0(ack0), .ack1(ack1), .err(err), .busy(busy), .grant_id(grant_id),
    .ain_out(ain_out), .shadow_y(shadow_y)
  );

  gesture_cmd_arbiter #(.CODE_CYCLES(3), .GAP_CYCLES(4)) dut_sweep (
    .clk(clk), .reset(reset), .req0(s_req0), .op0(s_op0), .req1(s_req1), .op1(s_op1),
    .ack0(s_ack0), .ack1(s_ack1), .err(s_err), .busy(s_busy), .grant_id(s_grant_id),
    .ain_out(s_ain_out), .shadow_y(s_shadow_y)
  );

  // Detector models: remember a nonzero code, apply it when the line returns to idle.
  logic       det_y, det2_y;
  logic [1:0] det_pend, det2_pend;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      det_y <= 1'b0; det_pend <= 2'b00; det2_y <= 1'b0; det2_pend <= 2'b00;
    end else begin
      if (ain_out != 2'b00) det_pend <= ain_out;
      else if (det_pend != 2'b00) begin
        det_y    <= (det_pend == 2'b11) ? 1'b1 : (det_pend == 2'b01) ? 1'b0 : ~det_y;
        det_pend <= 2'b00;
      end
      if (s_ain_out != 2'b00) det2_pend <= s_ain_out;
      else if (det2_pend != 2'b00) begin
        det2_y    <= (det2_pend == 2'b11) ? 1'b1 : (det2_pend == 2'b01) ? 1'b0 : ~det2_y;
        det2_pend <= 2'b00;
      end
    end
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int t;
    logic exp_id;
    reset = 1'b1;
    req0 = 1'b0; req1 = 1'b0; op0 = 2'b00; op1 = 2'b00;
    s_req0 = 1'b0; s_req1 = 1'b0; s_op0 = 2'b00; s_op1 = 2'b00;
    step(); step();
    check("rst_ain", ain_out, 2'b00);
    check("rst_busy", busy, 1'b0);
    check("rst_ack", {ack0, ack1, err}, 3'b000);
    check("rst_gid", grant_id, 1'b0);
    check("rst_shadow", shadow_y, 1'b0);
    reset = 1'b0;
    step();

    // Single set command
    req0 = 1'b1; op0 = OP_SET;
    step();
    check("set_c1_ain", ain_out, OP_SET);
    check("set_c1_busy", busy, 1'b1);
    step();
    check("set_c2_ain", ain_out, 2'b00);
    step();
    check("set_c3_ain", ain_out, 2'b00);
    check("set_c3_ack", ack0, 1'b0);
    step();
    check("set_c4_ack0", ack0, 1'b1);
    check("set_c4_err", err, 1'b0);
    req0 = 1'b0;
    step();
    check("set_c5_shadow", shadow_y, 1'b1);
    check("set_c5_det", shadow_y, det_y);
    check("set_c5_busy", busy, 1'b0);
    check("set_c5_ack0", ack0, 1'b0);

    // Contention after reset: clear from 0, then toggle
    reset = 1'b1; step(); reset = 1'b0;
    req0 = 1'b1; op0 = OP_CLR; req1 = 1'b1; op1 = OP_TGL;
    step();
    check("cont_c1_gid", grant_id, 1'b0);
    check("cont_c1_ain", ain_out, OP_CLR);
    step(); step(); step();
    check("cont_c4_ack", {ack1, ack0}, 2'b01);
    req0 = 1'b0;
    step();
    check("cont_c5_busy", busy, 1'b0);
    step();
    check("cont_c6_gid", grant_id, 1'b1);
    check("cont_c6_ain", ain_out, OP_TGL);
    step(); step(); step();
    check("cont_c9_ack", {ack1, ack0}, 2'b10);
    req1 = 1'b0;
    step();
    check("cont_shadow", shadow_y, 1'b1);
    check("cont_det", shadow_y, det_y);

    // Continuous alternation: 6 toggles, shadow 1 -> 1
    req0 = 1'b1; op0 = OP_TGL; req1 = 1'b1; op1 = OP_TGL;
    for (int k = 0; k < 6; k++) begin
      exp_id = k[0];
      t = 0;
      while (!(ack0 || ack1) && t < 20) begin
        step();
        t++;
      end
      check("alt_timeout", (t < 20), 1'b1);
      check("alt_gid", grant_id, exp_id);
      check("alt_ack", {ack1, ack0}, exp_id ? 2'b10 : 2'b01);
      if (exp_id) req1 = 1'b0; else req0 = 1'b0;
      if (k == 5) begin
        req0 = 1'b0; req1 = 1'b0;
      end
      step();
      check("alt_single_ack", {ack1, ack0}, 2'b00);
      if (k != 5) begin
        if (exp_id) req1 = 1'b1; else req0 = 1'b1;
      end
    end
    step();
    check("alt_shadow", shadow_y, 1'b1);
    check("alt_det", shadow_y, det_y);

    // Illegal opcode from requester 1
    req1 = 1'b1; op1 = OP_NOP;
    step();
    check("ill_c1_ack", {ack1, ack0, err}, 3'b101);
    check("ill_c1_ain", ain_out, 2'b00);
    req1 = 1'b0;
    step();
    check("ill_c2_ack", {ack1, err, busy}, 3'b000);
    check("ill_c2_ain", ain_out, 2'b00);
    check("ill_shadow", shadow_y, 1'b1);

    // Reset in the middle of DRIVE
    req0 = 1'b1; op0 = OP_SET;
    step();
    check("rdrv_c1_ain", ain_out, OP_SET);
    reset = 1'b1; req0 = 1'b0;
    #1;
    check("rdrv_ain", ain_out, 2'b00);
    check("rdrv_busy", busy, 1'b0);
    check("rdrv_ack", {ack0, ack1}, 2'b00);
    check("rdrv_shadow", shadow_y, 1'b0);
    step();
    reset = 1'b0;
    step(); step(); step();
    check("rdrv_no_ack", {ack0, ack1, busy}, 3'b000);
    req0 = 1'b1; op0 = OP_CLR; req1 = 1'b1; op1 = OP_TGL;
    step();
    check("rdrv_tie_gid", grant_id, 1'b0);
    step(); step(); step();
    check("rdrv_ack0", ack0, 1'b1);
    req0 = 1'b0; req1 = 1'b0;
    step(); step();

    // Parameter sweep: CODE=3, GAP=4 toggle
    s_req0 = 1'b1; s_op0 = OP_TGL;
    for (int c = 1; c <= 8; c++) begin
      step();
      check($sformatf("sw_c%0d_ain", c), s_ain_out, (c <= 3) ? OP_TGL : 2'b00);
      check($sformatf("sw_c%0d_ack", c), s_ack0, (c == 8) ? 1'b1 : 1'b0);
    end
    s_req0 = 1'b0;
    step();
    check("sw_shadow", s_shadow_y, 1'b1);
    check("sw_det", s_shadow_y, det2_y);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
